// File: rtl/req2send_arb_pkg.sv
// req2send_arb_pkg: shared types and defaults for the req2send arbiter.
// Holds the FSM state encoding, default parameter values and the
// pointer-width helper used by the arbiter and its picker.
package req2send_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  // Width of a requester index / round-robin pointer.
  function automatic int ptr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/req2send_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, lowest set bit at or above ptr_i, else wraps.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the pick.
// Ports: req_i (request vector), ptr_i (search start) -> any_o, oh_o (one-hot), idx_o (index).
module rr_pick
  import req2send_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_o,
  output logic [N-1:0]  oh_o,
  output logic [PW-1:0] idx_o
);

  logic          hi_any;
  logic          lo_any;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Two views of the same vector: "hi" only considers bits at or above the
  // pointer, "lo" considers every bit and serves as the wrap-around choice.
  // Scanning downward leaves the lowest matching index in each.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_any = 1'b1;
        lo_idx = PW'(i);
        if (PW'(i) >= ptr_i) begin
          hi_any = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
    any_o = lo_any;
    idx_o = hi_any ? hi_idx : lo_idx;
    oh_o  = '0;
    if (lo_any) oh_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/req2send_arb.sv
// req2send_arb: round-robin arbiter sharing one req2send channel among N_REQ requesters.
// Latency: grant/request/source_data one cycle after pick; done_o/err_o one cycle after ack/timeout.
// Backpressure: one transaction in flight; requesters hold req_i until their done_o/err_o.
// Ports: clk, reset_n; req_i/data_i in, grant_o/done_o/err_o out; request/source_data out, ack in.
module req2send_arb
  import req2send_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    request,
  output logic [DATA_W-1:0]       source_data,
  input  logic                    ack
);

  localparam int              PW       = ptr_w(N_REQ);
  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(N_REQ - 1);

  state_e             state_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      rr_ptr_d;
  logic [PW-1:0]      win_q;
  logic [CW-1:0]      cnt_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic [N_REQ-1:0]   err_q;
  logic               request_q;
  logic [DATA_W-1:0]  data_q;

  logic               pick_any;
  logic [N_REQ-1:0]   pick_oh;
  logic [PW-1:0]      pick_idx;
  logic [DATA_W-1:0]  data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = data_i[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .oh_o  (pick_oh),
    .idx_o (pick_idx)
  );

  // Pointer moves just past the winner once its transaction finishes.
  assign rr_ptr_d = (win_q == PTR_LAST) ? '0 : win_q + PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      request_q <= 1'b0;
      data_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        ST_IDLE: begin
          // An ack still high here belongs to nobody; wait it out.
          if (pick_any && !ack) begin
            state_q   <= ST_SEND;
            request_q <= 1'b1;
            grant_q   <= pick_oh;
            win_q     <= pick_idx;
            data_q    <= data_arr[pick_idx];
            cnt_q     <= '0;
          end
        end
        ST_SEND: begin
          // grant_q is the winner's one-hot, so it doubles as the pulse mask.
          if (ack) begin
            state_q   <= ST_RELEASE;
            request_q <= 1'b0;
            grant_q   <= '0;
            done_q    <= grant_q;
            rr_ptr_q  <= rr_ptr_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            request_q <= 1'b0;
            grant_q   <= '0;
            err_q     <= grant_q;
            rr_ptr_q  <= rr_ptr_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (!ack) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign request     = request_q;
  assign source_data = data_q;

endmodule

// File: tb/tb_req2send_arb.sv
// tb_req2send_arb: directed self-checking bench for req2send_arb.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_req2send_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic [3:0]  err_o;
  logic        request;
  logic [7:0]  source_data;
  logic        ack;

  int n_assert = 0;
  int n_fail   = 0;

  req2send_arb #(
    .N_REQ   (4),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .grant_o     (grant_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .request     (request),
    .source_data (source_data),
    .ack         (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One full transaction starting from IDLE with req_i already set:
  // grant edge, d SEND cycles before ack is sampled, hold extra RELEASE
  // cycles with ack high, then ack drops and the arbiter returns to IDLE.
  task automatic run_txn(input logic [3:0] exp_g, input logic [7:0] exp_d,
                         input int d, input int hold);
    tick();
    chk("grant", grant_o, exp_g);
    chk("request_up", request, 1);
    chk("src", source_data, exp_d);
    for (int k = 1; k < d; k++) begin
      tick();
      chk("req_hold", request, 1);
      chk("src_hold", source_data, exp_d);
      chk("done_early", done_o, 0);
    end
    ack = 1'b1;
    tick();
    chk("done", done_o, exp_g);
    chk("err_none", err_o, 0);
    chk("req_drop", request, 0);
    chk("grant_clr", grant_o, 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rel_done", done_o, 0);
      chk("rel_req", request, 0);
      chk("rel_grant", grant_o, 0);
    end
    ack = 1'b0;
    tick();
    chk("idle_done", done_o, 0);
    chk("idle_req", request, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_i   = 4'b0000;
    data_i  = {8'h44, 8'h33, 8'h22, 8'h11};
    ack     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_request", request, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_src", source_data, 0);
    reset_n = 1'b1;
    tick();

    // All four requesting: order 0,1,2,3,0, ack two cycles after request
    req_i = 4'b1111;
    run_txn(4'b0001, 8'h11, 2, 0);
    run_txn(4'b0010, 8'h22, 2, 0);
    run_txn(4'b0100, 8'h33, 2, 0);
    run_txn(4'b1000, 8'h44, 2, 0);
    run_txn(4'b0001, 8'h11, 2, 0);
    req_i = 4'b0000;

    // Single requester 0 with A5, ack after three SEND cycles, ack held in RELEASE
    data_i = {8'h44, 8'h33, 8'h22, 8'hA5};
    req_i  = 4'b0001;
    run_txn(4'b0001, 8'hA5, 3, 1);
    req_i  = 4'b0000;

    // Requester 2 with no ack: request high for 16 cycles, then err_o
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    req_i  = 4'b0100;
    tick();
    chk("to_grant", grant_o, 4'b0100);
    chk("to_request", request, 1);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("to_req_hold", request, 1);
      chk("to_err_early", err_o, 0);
    end
    tick();
    chk("to_req_drop", request, 0);
    chk("to_err", err_o, 4'b0100);
    chk("to_done_none", done_o, 0);
    chk("to_grant_clr", grant_o, 0);
    req_i = 4'b0000;
    tick();
    chk("to_err_pulse", err_o, 0);

    // Pointer sits at 3 after the timeout: 1 and 3 pending, 3 wins
    req_i = 4'b1010;
    run_txn(4'b1000, 8'h44, 2, 0);
    req_i = 4'b0000;

    // Stale ack in IDLE blocks the grant until it drops
    ack   = 1'b1;
    req_i = 4'b0010;
    tick();
    chk("stale_req", request, 0);
    chk("stale_grant", grant_o, 0);
    tick();
    chk("stale_req2", request, 0);
    chk("stale_grant2", grant_o, 0);
    ack = 1'b0;
    run_txn(4'b0010, 8'h22, 2, 0);
    req_i = 4'b0000;

    // Reset during SEND for requester 2, then arbitration restarts at 0
    req_i = 4'b0100;
    tick();
    chk("rs_grant", grant_o, 4'b0100);
    chk("rs_request", request, 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_req_async", request, 0);
    chk("rs_grant_async", grant_o, 0);
    chk("rs_src_async", source_data, 0);
    chk("rs_done_async", done_o, 0);
    chk("rs_err_async", err_o, 0);
    tick();
    chk("rs_done_held", done_o, 0);
    chk("rs_err_held", err_o, 0);
    req_i   = 4'b0101;
    reset_n = 1'b1;
    run_txn(4'b0001, 8'h11, 2, 0);
    run_txn(4'b0100, 8'h33, 2, 0);
    req_i = 4'b0000;

    // Winner drops req_i and its payload changes after grant: latched data still sent
    req_i = 4'b0010;
    tick();
    chk("dr_grant", grant_o, 4'b0010);
    chk("dr_src", source_data, 8'h22);
    req_i  = 4'b0000;
    data_i = {8'h44, 8'h33, 8'h77, 8'h11};
    tick();
    chk("dr_request", request, 1);
    chk("dr_src_hold", source_data, 8'h22);
    chk("dr_grant_hold", grant_o, 4'b0010);
    ack = 1'b1;
    tick();
    chk("dr_done", done_o, 4'b0010);
    chk("dr_req_drop", request, 0);
    ack = 1'b0;
    tick();
    chk("dr_done_pulse", done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
